id_hazard_stall_unit: RTL and testbench

- Producer-side companion to the ID-stage forwarding unit.
- Detects dependencies that forwarding cannot resolve: load-use, and branch/JALR operands still in flight in EX or in a MEM load.
- Drives PC/IF-ID hold, ID/EX bubble insertion and IF/ID flush, sequencing multi-cycle stalls with a small FSM.
- Keeps saturating stall and flush performance counters.

---
 rtl/id_hazard_stall_unit.sv | 126 ++++++++++++
 tb/tb_id_hazard_stall_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_stall_unit.sv
// ID-stage hazard/stall unit: detects load-use and branch-operand hazards that
// forwarding cannot cover, drives PC/IF-ID hold, ID/EX bubble and IF/ID flush.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal issue; need is evaluated, 1-cycle stalls stay here
//   ST_STALL2 | second cycle of a branch-after-load stall; need is ignored
module id_hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [6:0]       ID_opcode,
  input  logic [4:0]       ID_ReadRegNum1,
  input  logic [4:0]       ID_ReadRegNum2,
  input  logic             ID_branch_taken,
  input  logic             EX_cntl_RegWrite,
  input  logic             EX_cntl_MemRead,
  input  logic [4:0]       EX_WriteRegNum,
  input  logic             MEM_cntl_MemRead,
  input  logic [4:0]       MEM_WriteRegNum,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_STALL2 = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_is_br;
  logic       w_rs1_ex;
  logic       w_rs2_ex;
  logic       w_rs1_mem;
  logic       w_rs2_mem;
  logic       w_hit_ex;
  logic       w_hit_mem;
  logic [1:0] w_need;
  logic       w_stall_fsm;
  logic       w_stall;
  logic       w_flush;

  always_comb begin
    w_uses_rs1 = !(ID_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
    w_uses_rs2 = ID_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    w_is_br    = ID_opcode inside {7'b1100011, 7'b1100111};
  end

  // x0 is never a real dependency, so a zero register number never matches
  assign w_rs1_ex  = w_uses_rs1 && (ID_ReadRegNum1 != 5'd0) && (ID_ReadRegNum1 == EX_WriteRegNum);
  assign w_rs2_ex  = w_uses_rs2 && (ID_ReadRegNum2 != 5'd0) && (ID_ReadRegNum2 == EX_WriteRegNum);
  assign w_rs1_mem = w_uses_rs1 && (ID_ReadRegNum1 != 5'd0) && (ID_ReadRegNum1 == MEM_WriteRegNum);
  assign w_rs2_mem = w_uses_rs2 && (ID_ReadRegNum2 != 5'd0) && (ID_ReadRegNum2 == MEM_WriteRegNum);
  assign w_hit_ex  = ID_valid && (w_rs1_ex || w_rs2_ex);
  assign w_hit_mem = ID_valid && (w_rs1_mem || w_rs2_mem);

  always_comb begin
    w_need = 2'd0;
    if (w_is_br && EX_cntl_MemRead && w_hit_ex)
      w_need = 2'd2;
    else if (EX_cntl_MemRead && w_hit_ex)
      w_need = 2'd1;
    else if (w_is_br && EX_cntl_RegWrite && w_hit_ex)
      w_need = 2'd1;
    else if (w_is_br && MEM_cntl_MemRead && w_hit_mem)
      w_need = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall_fsm = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_stall_fsm = (w_need != 2'd0);
        if (w_need == 2'd2) w_state_nxt = ST_STALL2;
      end
      ST_STALL2: begin
        w_stall_fsm = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Reset forces the pipeline-enable view regardless of the inputs
  assign w_stall = w_stall_fsm && rst_n;
  assign w_flush = ID_branch_taken && ID_valid && !w_stall_fsm && rst_n;

  assign PC_Write    = !w_stall;
  assign IFID_Write  = !w_stall;
  assign IDEX_Bubble = w_stall;
  assign IFID_Flush  = w_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;

endmodule

// File: tb/tb_id_hazard_stall_unit.sv
// Self-checking bench for id_hazard_stall_unit: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_id_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_valid;
  logic [6:0]  ID_opcode;
  logic [4:0]  ID_ReadRegNum1, ID_ReadRegNum2;
  logic        ID_branch_taken;
  logic        EX_cntl_RegWrite, EX_cntl_MemRead;
  logic [4:0]  EX_WriteRegNum;
  logic        MEM_cntl_MemRead;
  logic [4:0]  MEM_WriteRegNum;
  logic        PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush;
  logic [15:0] stall_cycles, flush_cycles;
  logic        s_PC_Write, s_IFID_Write, s_IDEX_Bubble, s_IFID_Flush;
  logic [1:0]  s_stall_cycles, s_flush_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_hazard_stall_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_opcode(ID_opcode),
    .ID_ReadRegNum1(ID_ReadRegNum1), .ID_ReadRegNum2(ID_ReadRegNum2),
    .ID_branch_taken(ID_branch_taken), .EX_cntl_RegWrite(EX_cntl_RegWrite),
    .EX_cntl_MemRead(EX_cntl_MemRead), .EX_WriteRegNum(EX_WriteRegNum),
    .MEM_cntl_MemRead(MEM_cntl_MemRead), .MEM_WriteRegNum(MEM_WriteRegNum),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  id_hazard_stall_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_opcode(ID_opcode),
    .ID_ReadRegNum1(ID_ReadRegNum1), .ID_ReadRegNum2(ID_ReadRegNum2),
    .ID_branch_taken(ID_branch_taken), .EX_cntl_RegWrite(EX_cntl_RegWrite),
    .EX_cntl_MemRead(EX_cntl_MemRead), .EX_WriteRegNum(EX_WriteRegNum),
    .MEM_cntl_MemRead(MEM_cntl_MemRead), .MEM_WriteRegNum(MEM_WriteRegNum),
    .PC_Write(s_PC_Write), .IFID_Write(s_IFID_Write), .IDEX_Bubble(s_IDEX_Bubble),
    .IFID_Flush(s_IFID_Flush), .stall_cycles(s_stall_cycles), .flush_cycles(s_flush_cycles)
  );

  typedef struct {
    logic       valid;
    logic [6:0] op;
    logic [4:0] rs1, rs2;
    logic       taken;
    logic       ex_rw, ex_mr;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       exp_stall, exp_flush;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic stall, input logic flush);
    chk(name, {28'd0, PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush},
        {28'd0, ~stall, ~stall, stall, flush});
  endtask

  task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic tk, input logic exrw,
                        input logic exmr, input logic [4:0] exrd, input logic memmr,
                        input logic [4:0] memrd);
    ID_valid = v; ID_opcode = op; ID_ReadRegNum1 = r1; ID_ReadRegNum2 = r2;
    ID_branch_taken = tk; EX_cntl_RegWrite = exrw; EX_cntl_MemRead = exmr;
    EX_WriteRegNum = exrd; MEM_cntl_MemRead = memmr; MEM_WriteRegNum = memrd;
  endtask

  task automatic set_idle();
    set_in(1'b0, 7'b0010011, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; leaves reset released, same phase
  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Reference: collect the registers the ID instruction really reads, then
  // apply the hazard priority rules directly on that set.
  function automatic int ref_need(input logic v, input logic [6:0] op, input logic [4:0] r1,
                                  input logic [4:0] r2, input logic exrw, input logic exmr,
                                  input logic [4:0] exrd, input logic memmr, input logic [4:0] memrd);
    int  srcs[$];
    bit  br, ex_hit, mem_hit;
    if (!v) return 0;
    if (!(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111) && r1 != 0) srcs.push_back(int'(r1));
    if ((op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011) && r2 != 0) srcs.push_back(int'(r2));
    br = (op == 7'b1100011 || op == 7'b1100111);
    ex_hit = 0; mem_hit = 0;
    foreach (srcs[i]) begin
      if (srcs[i] == int'(exrd))  ex_hit = 1;
      if (srcs[i] == int'(memrd)) mem_hit = 1;
    end
    if (br && exmr && ex_hit) return 2;
    if (exmr && ex_hit) return 1;
    if (br && exrw && ex_hit) return 1;
    if (br && memmr && mem_hit) return 1;
    return 0;
  endfunction

  localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b1100111,
                                     7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011, 7'b0000011};

  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 7'b1100011, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3);
    #2;
    chk_ctl("reset_outputs", 1'b0, 1'b0);
    chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cycles), 32'd0);
    tick();
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    chk_ctl("after_reset_idle", 1'b0, 1'b0);
    chk("after_reset_cnt", 32'(stall_cycles), 32'd0);
    tick();

    // Single-cycle vectors, each applied from RUN with an idle cycle between
    vecs.push_back('{1, 7'b0110011, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 7'b0110111, 4, 0, 0, 0, 1, 4, 0, 0, 0, 0});
    vecs.push_back('{1, 7'b0010011, 1, 6, 0, 0, 1, 6, 0, 0, 0, 0});
    vecs.push_back('{1, 7'b0100011, 1, 6, 0, 0, 1, 6, 0, 0, 1, 0});
    vecs.push_back('{0, 7'b0110011, 3, 0, 0, 0, 1, 3, 0, 0, 0, 0});
    vecs.push_back('{1, 7'b1101111, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 7'b1100111, 2, 0, 1, 1, 0, 2, 0, 0, 1, 0});
    vecs.push_back('{1, 7'b1100011, 9, 0, 0, 0, 0, 0, 1, 9, 1, 0});
    vecs.push_back('{1, 7'b0110011, 9, 0, 0, 0, 0, 0, 1, 9, 0, 0});
    vecs.push_back('{1, 7'b0110011, 8, 0, 0, 1, 0, 8, 0, 0, 0, 0});
    vecs.push_back('{1, 7'b1101111, 5, 0, 0, 0, 1, 5, 0, 0, 0, 0});
    vecs.push_back('{1, 7'b0010111, 5, 0, 0, 0, 1, 5, 0, 0, 0, 0});
    vecs.push_back('{1, 7'b1100111, 1, 10, 0, 0, 1, 10, 0, 0, 0, 0});
    vecs.push_back('{1, 7'b0000011, 11, 0, 0, 0, 1, 11, 0, 0, 1, 0});
    vecs.push_back('{0, 7'b1100011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    do_reset();
    foreach (vecs[i]) begin
      set_in(vecs[i].valid, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].taken,
             vecs[i].ex_rw, vecs[i].ex_mr, vecs[i].ex_rd, vecs[i].mem_mr, vecs[i].mem_rd);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {28'd0, PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush},
          {28'd0, ~vecs[i].exp_stall, ~vecs[i].exp_stall, vecs[i].exp_stall, vecs[i].exp_flush});
      tick();
      set_idle();
      tick();
    end
    @(negedge clk);
    chk("vec_stall_cnt", 32'(stall_cycles), 32'd4);
    chk("vec_flush_cnt", 32'(flush_cycles), 32'd1);
    tick();

    // Load-use: one stall, released once EX no longer holds the load
    do_reset();
    set_in(1, 7'b0110011, 5'd3, 5'd0, 0, 1, 1, 5'd3, 0, 5'd0);
    @(negedge clk); chk_ctl("lu_stall", 1'b1, 1'b0);
    tick();
    set_in(1, 7'b0110011, 5'd3, 5'd0, 0, 0, 0, 5'd0, 1, 5'd3);
    @(negedge clk); chk_ctl("lu_release", 1'b0, 1'b0);
    chk("lu_cnt", 32'(stall_cycles), 32'd1);
    tick();

    // Branch after load: RUN -> STALL2 -> RUN
    do_reset();
    set_in(1, 7'b1100011, 5'd0, 5'd5, 0, 1, 1, 5'd5, 0, 5'd0);
    @(negedge clk); chk_ctl("bl_stall1", 1'b1, 1'b0);
    tick();
    set_in(1, 7'b1100011, 5'd0, 5'd5, 0, 0, 0, 5'd0, 1, 5'd5);
    @(negedge clk); chk_ctl("bl_stall2", 1'b1, 1'b0);
    tick();
    set_in(1, 7'b1100011, 5'd0, 5'd5, 1, 0, 0, 5'd0, 0, 5'd0);
    @(negedge clk); chk_ctl("bl_release", 1'b0, 1'b1);
    chk("bl_cnt", 32'(stall_cycles), 32'd2);
    tick();

    // Branch after ALU producer: one stall
    do_reset();
    set_in(1, 7'b1100111, 5'd7, 5'd0, 0, 1, 0, 5'd7, 0, 5'd0);
    @(negedge clk); chk_ctl("ba_stall", 1'b1, 1'b0);
    tick();
    set_in(1, 7'b1100111, 5'd7, 5'd0, 0, 0, 0, 5'd0, 0, 5'd7);
    @(negedge clk); chk_ctl("ba_release", 1'b0, 1'b0);
    chk("ba_cnt", 32'(stall_cycles), 32'd1);
    tick();

    // Reset landing in STALL2 leaves no residual stall
    do_reset();
    set_in(1, 7'b1100011, 5'd4, 5'd0, 0, 1, 1, 5'd4, 0, 5'd0);
    tick();
    set_idle();
    rst_n = 1'b0;
    #1;
    chk_ctl("rst_in_stall2", 1'b0, 1'b0);
    chk("rst_in_stall2_cnt", 32'(stall_cycles), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); chk_ctl("rst_stall2_released", 1'b0, 1'b0);
    tick();
    @(negedge clk); chk("rst_stall2_cnt", 32'(stall_cycles), 32'd0);
    tick();

    // Saturation on the 2-bit instance
    do_reset();
    set_in(1, 7'b0110011, 5'd3, 5'd0, 0, 0, 1, 5'd3, 0, 5'd0);
    for (int i = 0; i < 5; i++) tick();
    set_in(1, 7'b1101111, 5'd0, 5'd0, 1, 0, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 4; i++) tick();
    set_idle();
    @(negedge clk);
    chk("sat_stall_main", 32'(stall_cycles), 32'd5);
    chk("sat_stall_w2", 32'(s_stall_cycles), 32'd3);
    chk("sat_flush_main", 32'(flush_cycles), 32'd4);
    chk("sat_flush_w2", 32'(s_flush_cycles), 32'd3);
    tick();

    // Randomized traffic against the reference model
    begin
      int pending, need, ms, mf;
      logic st, fl;
      do_reset();
      pending = 0; ms = 0; mf = 0;
      for (int n = 0; n < 600; n++) begin
        set_in($urandom_range(0, 7) != 0, OPS[$urandom_range(0, 8)],
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)));
        need = ref_need(ID_valid, ID_opcode, ID_ReadRegNum1, ID_ReadRegNum2, EX_cntl_RegWrite,
                        EX_cntl_MemRead, EX_WriteRegNum, MEM_cntl_MemRead, MEM_WriteRegNum);
        st = (pending > 0) || (need > 0);
        fl = ID_branch_taken && ID_valid && !st;
        @(negedge clk);
        chk($sformatf("rnd%0d_ctl", n), {28'd0, PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush},
            {28'd0, ~st, ~st, st, fl});
        chk($sformatf("rnd%0d_cnt", n), {stall_cycles, flush_cycles}, {16'(ms), 16'(mf)});
        if (pending > 0) pending--;
        else if (need == 2) pending = 1;
        if (st && ms < 65535) ms++;
        if (fl && mf < 65535) mf++;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
